// File: rtl/tcp_loopback_stack_if.sv
// rtl/tcp_loopback_stack_if.sv - metadata and payload stream interfaces for the loopback stack
interface axis_meta #(parameter int W = 16);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

interface axi_stream #(parameter int W = 512);
  logic           valid;
  logic           ready;
  logic [W-1:0]   data;
  logic [W/8-1:0] keep;
  logic           last;
  modport master (output valid, output data, output keep, output last, input ready);
  modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/tcp_loopback_stack.sv
// rtl/tcp_loopback_stack.sv - listen table plus TX->buffer->RX segment loopback
// Optional counters enabled by TCP_LOOPBACK_STATS_EN.
module tcp_loopback_stack #(
  parameter int          DATA_WIDTH = 512,
  parameter int          FIFO_BEATS = 64,
  parameter logic [31:0] LOCAL_IP   = 32'h0A00_0001
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
`ifdef TCP_LOOPBACK_STATS_EN
  output logic [31:0] stat_tx_segments,
  output logic [15:0] stat_tx_errors,
  output logic [31:0] stat_rx_segments,
`endif
  axis_meta.slave     tcp_listen_req,
  axis_meta.master    tcp_listen_rsp,
  axis_meta.slave     tcp_tx_meta,
  axi_stream.slave    tcp_tx_data,
  axis_meta.master    tcp_tx_status,
  axis_meta.master    tcp_notification,
  axis_meta.slave     tcp_read_request,
  axis_meta.master    tcp_rx_meta,
  axi_stream.master   tcp_rx_data
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int AW    = $clog2(FIFO_BEATS);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_STATUS, TX_NOTIFY} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_META, RX_DATA} rx_state_e;

  // run_q holds every ready low until one edge after reset release
  logic            run_q;
  logic [3:0]      open_q;
  logic [15:0]     port_q [4];
  logic            lrsp_valid_q, lrsp_ok_q;
  tx_state_e       tx_st_q;
  logic [15:0]     tx_sess_q, tx_len_q;
  logic [1:0]      tx_err_q;
  logic [16:0]     tx_left_q;
  logic            sts_valid_q, ntf_valid_q;
  logic [63:0]     sts_data_q;
  logic [87:0]     ntf_data_q;
  rx_state_e       rx_st_q;
  logic [15:0]     rx_len_q, rxm_data_q;
  logic [16:0]     rx_left_q;
  logic            rxm_valid_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_BEATS];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d, free_q, free_d;
  logic [15:0]     segq_q [8];
  logic [2:0]      sq_wr_q, sq_rd_q;
  logic [3:0]      sq_cnt_q;

  logic            lst_hit, lst_free;
  logic [1:0]      lst_slot;
  logic [15:0]     m_sess, m_len, rx_rem;
  logic [16:0]     m_beats, head_beats;
  logic [1:0]      m_err;
  logic [29:0]     rem_space;
  logic            buf_wr, buf_rd, seg_push, seg_pop;
  logic [BYTES-1:0] rx_keep_last;
  logic            unused_bits;

  always_comb begin
    lst_hit  = 1'b0;
    lst_free = 1'b0;
    lst_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (open_q[i] && port_q[i] == tcp_listen_req.data) lst_hit = 1'b1;
      if (!open_q[i]) begin
        lst_free = 1'b1;
        lst_slot = 2'(i);
      end
    end
  end

  always_comb begin
    m_sess     = tcp_tx_meta.data[15:0];
    m_len      = tcp_tx_meta.data[31:16];
    m_beats    = ({1'b0, m_len} + 17'(BYTES - 1)) / 17'(BYTES);
    head_beats = ({1'b0, segq_q[sq_rd_q]} + 17'(BYTES - 1)) / 17'(BYTES);
    if (m_sess >= 16'd4 || !open_q[m_sess[1:0]])                m_err = 2'd1;
    else if (m_len == 16'd0 || m_beats > 17'(free_q))           m_err = 2'd2;
    else                                                        m_err = 2'd0;
    buf_wr    = tx_st_q == TX_DATA && tcp_tx_data.valid && tcp_tx_data.ready && tx_err_q == 2'd0;
    buf_rd    = rx_st_q == RX_DATA && tcp_rx_data.valid && tcp_rx_data.ready;
    seg_push  = tx_st_q == TX_NOTIFY && ntf_valid_q && tcp_notification.ready;
    seg_pop   = buf_rd && rx_left_q == 17'd1;
    count_d   = count_q + CW'(buf_wr) - CW'(buf_rd);
    free_q    = CW'(FIFO_BEATS) - count_q;
    free_d    = CW'(FIFO_BEATS) - count_d;
    rem_space = 30'(free_d) * 30'(BYTES);
    rx_rem    = rx_len_q % 16'(BYTES);
    rx_keep_last = (rx_rem == 16'd0) ? '1 : ~({BYTES{1'b1}} << rx_rem);
  end

  assign tcp_listen_req.ready   = run_q && !lrsp_valid_q;
  assign tcp_listen_rsp.valid   = lrsp_valid_q;
  assign tcp_listen_rsp.data    = {7'd0, lrsp_ok_q};
  assign tcp_tx_meta.ready      = run_q && tx_st_q == TX_IDLE && sq_cnt_q != 4'd8;
  assign tcp_tx_data.ready      = run_q && tx_st_q == TX_DATA;
  assign tcp_tx_status.valid    = sts_valid_q;
  assign tcp_tx_status.data     = sts_data_q;
  assign tcp_notification.valid = ntf_valid_q;
  assign tcp_notification.data  = ntf_data_q;
  assign tcp_read_request.ready = run_q && rx_st_q == RX_IDLE && sq_cnt_q != 4'd0;
  assign tcp_rx_meta.valid      = rxm_valid_q;
  assign tcp_rx_meta.data       = rxm_data_q;
  assign tcp_rx_data.valid      = rx_st_q == RX_DATA;
  assign tcp_rx_data.data       = mem_q[rd_ptr_q];
  assign tcp_rx_data.last       = rx_left_q == 17'd1;
  assign tcp_rx_data.keep       = (rx_left_q == 17'd1) ? rx_keep_last : '1;
  assign unused_bits = ^{tcp_tx_data.keep, tcp_tx_data.last, tcp_read_request.data[31:16]};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      run_q        <= 1'b0;
      open_q       <= 4'd0;
      lrsp_valid_q <= 1'b0;
      lrsp_ok_q    <= 1'b0;
      for (int i = 0; i < 4; i++) port_q[i] <= 16'd0;
    end else begin
      run_q <= 1'b1;
      if (tcp_listen_req.valid && tcp_listen_req.ready) begin
        lrsp_valid_q <= 1'b1;
        lrsp_ok_q    <= !lst_hit && lst_free;
        if (!lst_hit && lst_free) begin
          open_q[lst_slot] <= 1'b1;
          port_q[lst_slot] <= tcp_listen_req.data;
        end
      end else if (lrsp_valid_q && tcp_listen_rsp.ready) begin
        lrsp_valid_q <= 1'b0;
      end
    end
  end

  // Status payload is captured with the post-write free count so it stays stable while waiting
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tx_st_q     <= TX_IDLE;
      tx_sess_q   <= 16'd0;
      tx_len_q    <= 16'd0;
      tx_err_q    <= 2'd0;
      tx_left_q   <= 17'd0;
      sts_valid_q <= 1'b0;
      sts_data_q  <= 64'd0;
      ntf_valid_q <= 1'b0;
      ntf_data_q  <= 88'd0;
    end else begin
      case (tx_st_q)
        TX_IDLE: if (tcp_tx_meta.valid && tcp_tx_meta.ready) begin
          tx_sess_q <= m_sess;
          tx_len_q  <= m_len;
          tx_err_q  <= m_err;
          tx_left_q <= m_beats;
          if (m_len == 16'd0) begin
            tx_st_q     <= TX_STATUS;
            sts_valid_q <= 1'b1;
            sts_data_q  <= {m_err, rem_space, m_len, m_sess};
          end else begin
            tx_st_q <= TX_DATA;
          end
        end
        TX_DATA: if (tcp_tx_data.valid && tcp_tx_data.ready) begin
          tx_left_q <= tx_left_q - 17'd1;
          if (tx_left_q == 17'd1) begin
            tx_st_q     <= TX_STATUS;
            sts_valid_q <= 1'b1;
            sts_data_q  <= {tx_err_q, rem_space, tx_len_q, tx_sess_q};
          end
        end
        TX_STATUS: if (sts_valid_q && tcp_tx_status.ready) begin
          sts_valid_q <= 1'b0;
          if (tx_err_q == 2'd0) begin
            tx_st_q     <= TX_NOTIFY;
            ntf_valid_q <= 1'b1;
            ntf_data_q  <= {8'd0, port_q[tx_sess_q[1:0]], LOCAL_IP, tx_len_q, tx_sess_q};
          end else begin
            tx_st_q <= TX_IDLE;
          end
        end
        TX_NOTIFY: if (ntf_valid_q && tcp_notification.ready) begin
          ntf_valid_q <= 1'b0;
          tx_st_q     <= TX_IDLE;
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rx_st_q     <= RX_IDLE;
      rx_len_q    <= 16'd0;
      rx_left_q   <= 17'd0;
      rxm_valid_q <= 1'b0;
      rxm_data_q  <= 16'd0;
    end else begin
      case (rx_st_q)
        RX_IDLE: if (tcp_read_request.valid && tcp_read_request.ready) begin
          rx_len_q    <= segq_q[sq_rd_q];
          rx_left_q   <= head_beats;
          rxm_valid_q <= 1'b1;
          rxm_data_q  <= tcp_read_request.data[15:0];
          rx_st_q     <= RX_META;
        end
        RX_META: if (rxm_valid_q && tcp_rx_meta.ready) begin
          rxm_valid_q <= 1'b0;
          rx_st_q     <= RX_DATA;
        end
        RX_DATA: if (buf_rd) begin
          rx_left_q <= rx_left_q - 17'd1;
          if (rx_left_q == 17'd1) rx_st_q <= RX_IDLE;
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sq_wr_q  <= 3'd0;
      sq_rd_q  <= 3'd0;
      sq_cnt_q <= 4'd0;
    end else begin
      if (buf_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (buf_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (seg_push) sq_wr_q <= sq_wr_q + 3'd1;
      if (seg_pop)  sq_rd_q <= sq_rd_q + 3'd1;
      sq_cnt_q <= sq_cnt_q + 4'(seg_push) - 4'(seg_pop);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (buf_wr)   mem_q[wr_ptr_q] <= tcp_tx_data.data;
    if (seg_push) segq_q[sq_wr_q] <= tx_len_q;
  end

`ifdef TCP_LOOPBACK_STATS_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_tx_segments <= 32'd0;
      stat_tx_errors   <= 16'd0;
      stat_rx_segments <= 32'd0;
    end else begin
      if (tx_st_q == TX_STATUS && sts_valid_q && tcp_tx_status.ready) begin
        if (tx_err_q == 2'd0) stat_tx_segments <= stat_tx_segments + 32'd1;
        else                  stat_tx_errors   <= stat_tx_errors + 16'd1;
      end
      if (seg_pop) stat_rx_segments <= stat_rx_segments + 32'd1;
    end
  end
`endif
endmodule
